eth_rx_frame_fifo: RTL and testbench

Store-and-forward receive frame FIFO that sits directly downstream of the GMII frame receiver (`axis_gmii_rx`). It accepts that block's byte stream, which has no backpressure, and buffers each frame in block RAM. A frame is only made visible to the AXI-Stream consumer once it has fully arrived with `tuser` low. Errored, runt and overflowing frames are discarded atomically, and the trailing 4-byte FCS is optionally stripped.

---
 rtl/eth_rx_frame_fifo.sv | 187 ++++++++++++++++++
 tb/tb_eth_rx_frame_fifo.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward receive frame FIFO. Buffers each frame from the GMII receiver
// and releases it to the AXI-Stream consumer only once it has fully arrived
// without error. Bad, runt and overflowing frames are dropped as a whole.
module eth_rx_frame_fifo #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned STRIP_FCS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] input_axis_tdata,
  input  logic       input_axis_tvalid,
  input  logic       input_axis_tlast,
  input  logic       input_axis_tuser,
  output logic [7:0] output_axis_tdata,
  output logic       output_axis_tvalid,
  input  logic       output_axis_tready,
  output logic       output_axis_tlast,
  output logic       status_good_frame,
  output logic       status_bad_frame,
  output logic       status_overflow,
  output logic       status_runt
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned MEM_W = 9;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  logic [MEM_W-1:0] mem [DEPTH];

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_cur_q, wr_ptr_cur_d;
  logic [PTR_W-1:0] wr_ptr_commit_q, wr_ptr_commit_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [3:0][7:0]  dl_q, dl_d;
  logic [2:0]       occ_q, occ_d;
  logic             good_q, good_d, bad_q, bad_d, ovf_q, ovf_d, runt_q, runt_d;

  logic [MEM_W-1:0] mem_rdata_q;
  logic             mem_valid_q;
  logic             out_valid_q, out_last_q;
  logic [7:0]       out_data_q;

  logic             mem_we_c;
  logic [MEM_W-1:0] mem_wdata_c;
  logic             wr_req_c, runt_c, ovf_c, full_c, empty_c, out_ready_c, rd_en_c;

  // Read-side handshake and occupancy flags
  always_comb begin
    empty_c     = (wr_ptr_commit_q == rd_ptr_q);
    out_ready_c = !out_valid_q || output_axis_tready;
    rd_en_c     = !empty_c && (!mem_valid_q || out_ready_c);
    full_c      = ((wr_ptr_cur_q - rd_ptr_q) == PTR_W'(DEPTH)) && !rd_en_c;
  end

  // Write FSM: delay line, frame write, commit/drop decision on tlast
  always_comb begin
    state_d         = state_q;
    wr_ptr_cur_d    = wr_ptr_cur_q;
    wr_ptr_commit_d = wr_ptr_commit_q;
    dl_d            = dl_q;
    occ_d           = occ_q;
    good_d          = 1'b0;
    bad_d           = 1'b0;
    ovf_d           = 1'b0;
    runt_d          = 1'b0;
    mem_we_c        = 1'b0;
    mem_wdata_c     = {input_axis_tlast, input_axis_tdata};
    wr_req_c        = 1'b1;
    runt_c          = 1'b0;
    if (STRIP_FCS != 0) begin
      wr_req_c    = (occ_q == 3'd4);
      mem_wdata_c = {input_axis_tlast, dl_q[3]};
      runt_c      = (occ_q != 3'd4);
    end
    ovf_c = (state_q == ST_DROP) || (wr_req_c && full_c);

    if (input_axis_tvalid) begin
      if (STRIP_FCS != 0) begin
        dl_d = {dl_q[2:0], input_axis_tdata};
        if (input_axis_tlast) begin
          occ_d = 3'd0;
        end else if (occ_q != 3'd4) begin
          occ_d = occ_q + 3'd1;
        end
      end
      if (input_axis_tlast) begin
        state_d = ST_IDLE;
        if (ovf_c) begin
          ovf_d        = 1'b1;
          wr_ptr_cur_d = wr_ptr_commit_q;
        end else if (input_axis_tuser) begin
          bad_d        = 1'b1;
          wr_ptr_cur_d = wr_ptr_commit_q;
        end else if (runt_c) begin
          runt_d       = 1'b1;
          wr_ptr_cur_d = wr_ptr_commit_q;
        end else begin
          good_d          = 1'b1;
          mem_we_c        = wr_req_c;
          wr_ptr_cur_d    = wr_ptr_cur_q + PTR_W'(wr_req_c);
          wr_ptr_commit_d = wr_ptr_cur_q + PTR_W'(wr_req_c);
        end
      end else if (ovf_c) begin
        state_d = ST_DROP;
      end else begin
        state_d = ST_WRITE;
        if (wr_req_c) begin
          mem_we_c     = 1'b1;
          wr_ptr_cur_d = wr_ptr_cur_q + PTR_W'(1);
        end
      end
    end
  end

  // Write-side state, pointers, delay line and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      wr_ptr_cur_q    <= '0;
      wr_ptr_commit_q <= '0;
      dl_q            <= '0;
      occ_q           <= 3'd0;
      good_q          <= 1'b0;
      bad_q           <= 1'b0;
      ovf_q           <= 1'b0;
      runt_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_cur_q    <= wr_ptr_cur_d;
      wr_ptr_commit_q <= wr_ptr_commit_d;
      dl_q            <= dl_d;
      occ_q           <= occ_d;
      good_q          <= good_d;
      bad_q           <= bad_d;
      ovf_q           <= ovf_d;
      runt_q          <= runt_d;
    end
  end

  // Frame buffer storage with registered read port
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[wr_ptr_cur_q[ADDR_WIDTH-1:0]] <= mem_wdata_c;
    end
    if (rd_en_c) begin
      mem_rdata_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    end
  end

  // Read pipeline: RAM read stage feeding the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      mem_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= 8'd0;
    end else begin
      if (rd_en_c) begin
        rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
        mem_valid_q <= 1'b1;
      end else if (out_ready_c) begin
        mem_valid_q <= 1'b0;
      end
      if (out_ready_c) begin
        out_valid_q <= mem_valid_q;
        if (mem_valid_q) begin
          out_last_q <= mem_rdata_q[8];
          out_data_q <= mem_rdata_q[7:0];
        end
      end
    end
  end

  assign output_axis_tdata  = out_data_q;
  assign output_axis_tvalid = out_valid_q;
  assign output_axis_tlast  = out_last_q;
  assign status_good_frame  = good_q;
  assign status_bad_frame   = bad_q;
  assign status_overflow    = ovf_q;
  assign status_runt        = runt_q;

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Directed bench for eth_rx_frame_fifo: default build (A), small buffer (B),
// and a no-FCS-strip small buffer (C).
module tb_eth_rx_frame_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] in_data;
  logic       in_last, in_user;
  logic [2:0] in_valid;
  logic [7:0] out_data [3];
  logic [2:0] out_valid, out_last, out_ready;
  logic [2:0] st_good, st_bad, st_ovf, st_runt;

  int n_cmp = 0;
  int n_err = 0;

  eth_rx_frame_fifo #(.ADDR_WIDTH(11), .STRIP_FCS(1)) dut_a (
    .clk(clk), .rst(rst), .input_axis_tdata(in_data), .input_axis_tvalid(in_valid[0]),
    .input_axis_tlast(in_last), .input_axis_tuser(in_user), .output_axis_tdata(out_data[0]),
    .output_axis_tvalid(out_valid[0]), .output_axis_tready(out_ready[0]), .output_axis_tlast(out_last[0]),
    .status_good_frame(st_good[0]), .status_bad_frame(st_bad[0]), .status_overflow(st_ovf[0]), .status_runt(st_runt[0]));

  eth_rx_frame_fifo #(.ADDR_WIDTH(6), .STRIP_FCS(1)) dut_b (
    .clk(clk), .rst(rst), .input_axis_tdata(in_data), .input_axis_tvalid(in_valid[1]),
    .input_axis_tlast(in_last), .input_axis_tuser(in_user), .output_axis_tdata(out_data[1]),
    .output_axis_tvalid(out_valid[1]), .output_axis_tready(out_ready[1]), .output_axis_tlast(out_last[1]),
    .status_good_frame(st_good[1]), .status_bad_frame(st_bad[1]), .status_overflow(st_ovf[1]), .status_runt(st_runt[1]));

  eth_rx_frame_fifo #(.ADDR_WIDTH(5), .STRIP_FCS(0)) dut_c (
    .clk(clk), .rst(rst), .input_axis_tdata(in_data), .input_axis_tvalid(in_valid[2]),
    .input_axis_tlast(in_last), .input_axis_tuser(in_user), .output_axis_tdata(out_data[2]),
    .output_axis_tvalid(out_valid[2]), .output_axis_tready(out_ready[2]), .output_axis_tlast(out_last[2]),
    .status_good_frame(st_good[2]), .status_bad_frame(st_bad[2]), .status_overflow(st_ovf[2]), .status_runt(st_runt[2]));

  // Output monitor for the selected DUT: byte capture, status counts, stall stability
  logic [1:0] mon_sel = 2'd0;
  logic [8:0] got [$];
  int         n_good = 0, n_bad = 0, n_ovf = 0, n_runt = 0, stall_err = 0;
  logic       stall_pend = 1'b0;
  logic [8:0] stall_val = 9'd0;

  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend && (!out_valid[mon_sel] || {out_last[mon_sel], out_data[mon_sel]} !== stall_val))
        stall_err++;
      stall_pend = out_valid[mon_sel] && !out_ready[mon_sel];
      stall_val  = {out_last[mon_sel], out_data[mon_sel]};
      if (out_valid[mon_sel] && out_ready[mon_sel]) got.push_back({out_last[mon_sel], out_data[mon_sel]});
      n_good += int'(st_good[mon_sel]);
      n_bad  += int'(st_bad[mon_sel]);
      n_ovf  += int'(st_ovf[mon_sel]);
      n_runt += int'(st_runt[mon_sel]);
    end
  end

  // Drive one frame, one byte per cycle; returns just after the edge sampling tlast
  task automatic send_frame(input int d, input int len, input logic user, input logic [7:0] base);
    for (int i = 0; i < len; i++) begin
      in_data     = base + 8'(i);
      in_last     = (i == len - 1);
      in_user     = user && (i == len - 1);
      in_valid[d] = 1'b1;
      @(posedge clk); #1;
    end
    in_valid[d] = 1'b0;
    in_last     = 1'b0;
    in_user     = 1'b0;
  endtask

  task automatic wait_bytes(input int target, input int budget);
    for (int c = 0; c < budget && got.size() < target; c++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 3'b000) begin n_err++; $display("FAIL reset_tvalid: got %b expected 000", out_valid); end
    n_cmp++; if (out_last !== 3'b000) begin n_err++; $display("FAIL reset_tlast: got %b expected 000", out_last); end
    n_cmp++; if ({out_data[0], out_data[1], out_data[2]} !== 24'd0) begin n_err++; $display("FAIL reset_tdata: got %h/%h/%h expected 0", out_data[0], out_data[1], out_data[2]); end
    n_cmp++; if ({st_good, st_bad, st_ovf, st_runt} !== 12'd0) begin n_err++; $display("FAIL reset_status: got %h expected 0", {st_good, st_bad, st_ovf, st_runt}); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_good_frame();
    int start, g0, lat, errs;
    logic seen;
    mon_sel = 2'd0; start = got.size(); g0 = n_good;
    send_frame(0, 64, 1'b0, 8'h10);
    seen = 1'b0; lat = -1;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_cmp++; if (st_good[0] !== 1'b1) begin n_err++; $display("FAIL good_pulse_hi: got %b expected 1", st_good[0]); end
      end
      if (c == 1) begin
        n_cmp++; if (st_good[0] !== 1'b0) begin n_err++; $display("FAIL good_pulse_lo: got %b expected 0", st_good[0]); end
      end
      if (out_valid[0]) begin seen = 1'b1; lat = c; end
      else @(posedge clk);
    end
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL good_latency: got %0d expected 2", lat); end
    wait_bytes(start + 60, 300);
    n_cmp++; if (got.size() - start !== 60) begin n_err++; $display("FAIL good_len: got %0d expected 60", got.size() - start); end
    errs = 0;
    for (int i = 0; i < 60; i++)
      if (start + i >= got.size() || got[start + i] !== {(i == 59), 8'h10 + 8'(i)}) errs++;
    n_cmp++; if (errs !== 0) begin n_err++; $display("FAIL good_data: got %0d bad bytes expected 0", errs); end
    n_cmp++; if (n_good - g0 !== 1) begin n_err++; $display("FAIL good_count: got %0d expected 1", n_good - g0); end
  endtask

  task automatic test_bad_frame();
    int start, g0, b0, r0, errs;
    mon_sel = 2'd0; start = got.size(); g0 = n_good; b0 = n_bad; r0 = n_runt;
    send_frame(0, 64, 1'b1, 8'h40);
    send_frame(0, 3, 1'b1, 8'h50);
    send_frame(0, 64, 1'b0, 8'h80);
    wait_bytes(start + 60, 300);
    n_cmp++; if (n_bad - b0 !== 2) begin n_err++; $display("FAIL bad_count: got %0d expected 2", n_bad - b0); end
    n_cmp++; if (n_runt - r0 !== 0) begin n_err++; $display("FAIL bad_over_runt: got %0d expected 0", n_runt - r0); end
    n_cmp++; if (n_good - g0 !== 1) begin n_err++; $display("FAIL bad_then_good: got %0d expected 1", n_good - g0); end
    n_cmp++; if (got.size() - start !== 60) begin n_err++; $display("FAIL bad_len: got %0d expected 60", got.size() - start); end
    errs = 0;
    for (int i = 0; i < 60; i++)
      if (start + i >= got.size() || got[start + i] !== {(i == 59), 8'h80 + 8'(i)}) errs++;
    n_cmp++; if (errs !== 0) begin n_err++; $display("FAIL bad_data: got %0d bad bytes expected 0", errs); end
  endtask

  task automatic test_runt();
    int start, g0, r0;
    mon_sel = 2'd0; start = got.size(); g0 = n_good; r0 = n_runt;
    send_frame(0, 4, 1'b0, 8'h20);
    send_frame(0, 1, 1'b0, 8'h28);
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (n_runt - r0 !== 2) begin n_err++; $display("FAIL runt_count: got %0d expected 2", n_runt - r0); end
    n_cmp++; if (got.size() - start !== 0) begin n_err++; $display("FAIL runt_no_output: got %0d expected 0", got.size() - start); end
    send_frame(0, 5, 1'b0, 8'h30);
    wait_bytes(start + 1, 50);
    n_cmp++; if (got.size() - start !== 1) begin n_err++; $display("FAIL runt_next_len: got %0d expected 1", got.size() - start); end
    n_cmp++; if (got.size() > start && got[start] !== 9'h130) begin n_err++; $display("FAIL runt_next_byte: got %h expected 130", got[start]); end
    n_cmp++; if (n_good - g0 !== 1) begin n_err++; $display("FAIL runt_next_good: got %0d expected 1", n_good - g0); end
  endtask

  task automatic test_back_to_back();
    int start, g0, s0, errs, k;
    logic bp_done;
    logic [8:0] exp [$];
    int lens [3] = '{10, 64, 1500};
    logic [7:0] bases [3] = '{8'h00, 8'h50, 8'hA0};
    mon_sel = 2'd0; start = got.size(); g0 = n_good; s0 = stall_err;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < lens[f] - 4; i++) exp.push_back({(i == lens[f] - 5), bases[f] + 8'(i)});
    bp_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 3; f++) send_frame(0, lens[f], 1'b0, bases[f]);
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          out_ready[0] = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    for (int c = 0; c < 10000 && got.size() < start + exp.size(); c++) begin
      out_ready[0] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    out_ready[0] = 1'b1;
    wait_bytes(start + exp.size(), 10);
    n_cmp++; if (got.size() - start !== exp.size()) begin n_err++; $display("FAIL bp_len: got %0d expected %0d", got.size() - start, exp.size()); end
    errs = 0;
    for (int i = 0; i < exp.size(); i++) begin
      k = start + i;
      if (k >= got.size() || got[k] !== exp[i]) errs++;
    end
    n_cmp++; if (errs !== 0) begin n_err++; $display("FAIL bp_data: got %0d bad bytes expected 0", errs); end
    n_cmp++; if (stall_err - s0 !== 0) begin n_err++; $display("FAIL bp_stall_stable: got %0d violations expected 0", stall_err - s0); end
    n_cmp++; if (n_good - g0 !== 3) begin n_err++; $display("FAIL bp_good_count: got %0d expected 3", n_good - g0); end
  endtask

  task automatic test_overflow();
    int start, g0, o0, b0, s0, errs;
    mon_sel = 2'd1; out_ready[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = got.size(); g0 = n_good; o0 = n_ovf; b0 = n_bad; s0 = stall_err;
    send_frame(1, 40, 1'b0, 8'h00);
    send_frame(1, 40, 1'b0, 8'h60);
    send_frame(1, 40, 1'b1, 8'hB0);
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (n_good - g0 !== 1) begin n_err++; $display("FAIL ovf_first_commit: got %0d expected 1", n_good - g0); end
    n_cmp++; if (n_ovf - o0 !== 2) begin n_err++; $display("FAIL ovf_count: got %0d expected 2", n_ovf - o0); end
    n_cmp++; if (n_bad - b0 !== 0) begin n_err++; $display("FAIL ovf_over_bad: got %0d expected 0", n_bad - b0); end
    out_ready[1] = 1'b1;
    wait_bytes(start + 36, 200);
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (got.size() - start !== 36) begin n_err++; $display("FAIL ovf_len: got %0d expected 36", got.size() - start); end
    errs = 0;
    for (int i = 0; i < 36; i++)
      if (start + i >= got.size() || got[start + i] !== {(i == 35), 8'(i)}) errs++;
    n_cmp++; if (errs !== 0) begin n_err++; $display("FAIL ovf_data: got %0d bad bytes expected 0", errs); end
    n_cmp++; if (stall_err - s0 !== 0) begin n_err++; $display("FAIL ovf_stall_stable: got %0d violations expected 0", stall_err - s0); end
    start = got.size();
    send_frame(1, 10, 1'b0, 8'hE0);
    wait_bytes(start + 6, 50);
    n_cmp++; if (got.size() - start !== 6) begin n_err++; $display("FAIL ovf_recover_len: got %0d expected 6", got.size() - start); end
    n_cmp++; if (got.size() >= start + 6 && got[start + 5] !== 9'h1E5) begin n_err++; $display("FAIL ovf_recover_last: got %h expected 1e5", got[start + 5]); end
  endtask

  task automatic test_no_strip();
    int start, g0, o0, b0, errs;
    mon_sel = 2'd2; out_ready[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = got.size(); g0 = n_good; o0 = n_ovf; b0 = n_bad;
    send_frame(2, 32, 1'b0, 8'h00);
    wait_bytes(start + 32, 100);
    n_cmp++; if (got.size() - start !== 32) begin n_err++; $display("FAIL nofcs_full_len: got %0d expected 32", got.size() - start); end
    errs = 0;
    for (int i = 0; i < 32; i++)
      if (start + i >= got.size() || got[start + i] !== {(i == 31), 8'(i)}) errs++;
    n_cmp++; if (errs !== 0) begin n_err++; $display("FAIL nofcs_full_data: got %0d bad bytes expected 0", errs); end
    start = got.size();
    send_frame(2, 33, 1'b0, 8'h40);
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (n_ovf - o0 !== 1) begin n_err++; $display("FAIL nofcs_ovf: got %0d expected 1", n_ovf - o0); end
    n_cmp++; if (got.size() - start !== 0) begin n_err++; $display("FAIL nofcs_ovf_len: got %0d expected 0", got.size() - start); end
    send_frame(2, 1, 1'b0, 8'h77);
    send_frame(2, 3, 1'b1, 8'h88);
    send_frame(2, 3, 1'b0, 8'h90);
    wait_bytes(start + 4, 50);
    n_cmp++; if (got.size() - start !== 4) begin n_err++; $display("FAIL nofcs_small_len: got %0d expected 4", got.size() - start); end
    errs = 0;
    if (got.size() >= start + 4) begin
      if (got[start]     !== 9'h177) errs++;
      if (got[start + 1] !== 9'h090) errs++;
      if (got[start + 2] !== 9'h091) errs++;
      if (got[start + 3] !== 9'h192) errs++;
    end
    n_cmp++; if (errs !== 0) begin n_err++; $display("FAIL nofcs_small_data: got %0d bad bytes expected 0", errs); end
    n_cmp++; if (n_good - g0 !== 3 || n_bad - b0 !== 1) begin n_err++; $display("FAIL nofcs_status: got good %0d bad %0d expected 3 1", n_good - g0, n_bad - b0); end
  endtask

  task automatic test_reset_mid_frame();
    int start, errs;
    mon_sel = 2'd0; out_ready[0] = 1'b0;
    send_frame(0, 30, 1'b0, 8'h55);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'hC0 + 8'(i); in_valid[0] = 1'b1;
      @(posedge clk); #1;
    end
    in_valid[0] = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid[0] !== 1'b0 || out_last[0] !== 1'b0 || out_data[0] !== 8'h00) begin n_err++; $display("FAIL rst_mid_outputs: got v%b l%b d%h expected v0 l0 d00", out_valid[0], out_last[0], out_data[0]); end
    @(posedge clk); #1;
    rst = 1'b0; out_ready[0] = 1'b1;
    start = got.size();
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (got.size() - start !== 0) begin n_err++; $display("FAIL rst_mid_empty: got %0d bytes expected 0", got.size() - start); end
    send_frame(0, 64, 1'b0, 8'h01);
    wait_bytes(start + 60, 300);
    n_cmp++; if (got.size() - start !== 60) begin n_err++; $display("FAIL rst_mid_next_len: got %0d expected 60", got.size() - start); end
    errs = 0;
    for (int i = 0; i < 60; i++)
      if (start + i >= got.size() || got[start + i] !== {(i == 59), 8'h01 + 8'(i)}) errs++;
    n_cmp++; if (errs !== 0) begin n_err++; $display("FAIL rst_mid_next_data: got %0d bad bytes expected 0", errs); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 3'b000; in_data = 8'd0; in_last = 1'b0; in_user = 1'b0;
    out_ready = 3'b101;
    test_reset();
    test_good_frame();
    test_bad_frame();
    test_runt();
    test_back_to_back();
    test_overflow();
    test_no_strip();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
